// File: rtl/spike_mac.sv
// spike_mac
// Spike-gated multiply-accumulate for the neuron core input-current stage.
// Each binary spike selects its lane's signed weight. The selected weights
// are summed in a balanced adder tree and registered as result. Inputs
// sampled at one rising edge appear on result right after that edge.
// Nothing accumulates from one cycle to the next.
//
// Ports:
//   CLK        - rising-edge clock
//   RESET      - asynchronous active-high reset; forces result to 0
//   spike_in   - one spike bit per lane
//   weights_in - packed signed weights, lane i at [i*WEIGHT_W +: WEIGHT_W]
//   result     - registered gated sum (wrapped or saturated, per SATURATE)
module spike_mac #(
   parameter int N_INPUTS = 4,
   parameter int WEIGHT_W = 32,
   parameter int SATURATE = 0
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic [N_INPUTS-1:0]            spike_in,
   input  logic [N_INPUTS*WEIGHT_W-1:0]   weights_in,
   output logic [WEIGHT_W-1:0]            result
);

   // Tree depth and leaf count. The leaf count is padded to a power of two.
   // Padding leaves are tied to zero.
   localparam int LVLS  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 0;
   localparam int P     = 1 << LVLS;
   localparam int SUM_W = WEIGHT_W + LVLS;

   // Saturation bounds, sign-extended to the full sum width.
   localparam logic signed [SUM_W-1:0] SUM_MAX =
      SUM_W'($signed({1'b0, {(WEIGHT_W-1){1'b1}}}));
   localparam logic signed [SUM_W-1:0] SUM_MIN =
      SUM_W'($signed({1'b1, {(WEIGHT_W-1){1'b0}}}));

   logic signed [SUM_W-1:0] leaf [P];
   logic signed [SUM_W-1:0] sum_full;
   logic [WEIGHT_W-1:0]     result_d;
   logic [WEIGHT_W-1:0]     result_q;

   // Gating is a select, not a multiply. An unselected lane contributes a
   // hard zero, so its value (even X/Z) never reaches the sum.
   for (genvar g = 0; g < P; g++) begin : leaf_g
      if (g < N_INPUTS) begin : real_g
         assign leaf[g] = spike_in[g]
                          ? SUM_W'($signed(weights_in[g*WEIGHT_W +: WEIGHT_W]))
                          : '0;
      end else begin : pad_g
         assign leaf[g] = '0;
      end
   end

   // Each tree level is its own array, so no signal feeds back into itself.
   // Level l holds P >> (l+1) partial sums.
   for (genvar l = 0; l < LVLS; l++) begin : lvl_g
      localparam int CNT = P >> (l + 1);
      logic signed [SUM_W-1:0] node [CNT];
      for (genvar j = 0; j < CNT; j++) begin : add_g
         if (l == 0) begin : from_leaf_g
            assign node[j] = leaf[2*j] + leaf[2*j+1];
         end else begin : from_lvl_g
            assign node[j] = lvl_g[l-1].node[2*j] + lvl_g[l-1].node[2*j+1];
         end
      end
   end

   if (LVLS == 0) begin : root_leaf_g
      assign sum_full = leaf[0];
   end else begin : root_tree_g
      assign sum_full = lvl_g[LVLS-1].node[0];
   end

   // Convert the widened sum to the output width. With wrap-around, keep
   // the low bits. With saturation, clamp to the signed range.
   always_comb begin
      result_d = sum_full[WEIGHT_W-1:0];
      if (SATURATE != 0) begin
         if (sum_full > SUM_MAX) begin
            result_d = SUM_MAX[WEIGHT_W-1:0];
         end else if (sum_full < SUM_MIN) begin
            result_d = SUM_MIN[WEIGHT_W-1:0];
         end
      end
   end

   // RESET clears the output at once and discards in-flight data.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_spike_mac.sv
// tb_spike_mac
// Scoreboard bench for spike_mac. Two instances share the same inputs:
//   - dut_wrap uses wrap-around on overflow.
//   - dut_sat clamps to the signed range.
// The driver pushes the model's expected values into queues. A monitor pops
// them one cycle later and compares them with both outputs.
module tb_spike_mac;

   localparam int N = 4;
   localparam int W = 32;

   logic           CLK;
   logic           RESET;
   logic [N-1:0]   spike_in;
   logic [N*W-1:0] weights_in;
   logic [W-1:0]   result_wrap;
   logic [W-1:0]   result_sat;

   int checks;
   int errors;

   logic [W-1:0] exp_wrap_q [$];
   logic [W-1:0] exp_sat_q  [$];
   string        exp_name_q [$];

   spike_mac #(.N_INPUTS(N), .WEIGHT_W(W), .SATURATE(0)) dut_wrap (
      .CLK        (CLK),
      .RESET      (RESET),
      .spike_in   (spike_in),
      .weights_in (weights_in),
      .result     (result_wrap)
   );

   spike_mac #(.N_INPUTS(N), .WEIGHT_W(W), .SATURATE(1)) dut_sat (
      .CLK        (CLK),
      .RESET      (RESET),
      .spike_in   (spike_in),
      .weights_in (weights_in),
      .result     (result_sat)
   );

   // 10-time-unit clock period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: the exact integer sum of the selected signed weights.
   function automatic longint model_sum(input logic [N-1:0] sp, input logic [N*W-1:0] w);
      longint s;
      logic signed [W-1:0] lane;
      s = 0;
      for (int i = 0; i < N; i++) begin
         lane = w[i*W +: W];
         if (sp[i]) s += longint'(lane);
      end
      return s;
   endfunction

   // Wrap-around output: the sum modulo 2^W.
   function automatic logic [W-1:0] model_wrap(input longint s);
      return s[W-1:0];
   endfunction

   // Saturated output: the sum clamped to the signed W-bit range.
   function automatic logic [W-1:0] model_sat(input longint s);
      if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return s[W-1:0];
   endfunction

   task automatic checkOutput(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive one input set just after a falling edge. Queue what the next
   // rising edge must produce. rst_val is the level RESET holds across that
   // edge.
   task automatic applyStimulus(input logic rst_val, input logic [N-1:0] sp,
                                input logic [N*W-1:0] w, input string name);
      longint s;
      @(negedge CLK);
      RESET      = rst_val;
      spike_in   = sp;
      weights_in = w;
      s = model_sum(sp, w);
      exp_wrap_q.push_back(rst_val ? '0 : model_wrap(s));
      exp_sat_q.push_back(rst_val ? '0 : model_sat(s));
      exp_name_q.push_back(name);
   endtask

   function automatic logic [W-1:0] randWeight();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'($urandom_range(0, 200)) - 32'd100;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: one cycle after each queued stimulus, check both outputs.
   always begin
      @(posedge CLK);
      #1;
      if (exp_wrap_q.size() > 0) begin
         string        nm;
         logic [W-1:0] ew;
         logic [W-1:0] es;
         nm = exp_name_q.pop_front();
         ew = exp_wrap_q.pop_front();
         es = exp_sat_q.pop_front();
         checkOutput({nm, "/wrap"}, result_wrap, ew);
         checkOutput({nm, "/sat"},  result_sat,  es);
      end
   end

   initial begin
      logic [N*W-1:0] w;
      logic [N-1:0]   sp;
      checks     = 0;
      errors     = 0;
      RESET      = 1'b1;
      spike_in   = 4'b0001;
      weights_in = 128'd64;
      #1;
      checkOutput("reset_async/wrap", result_wrap, '0);
      checkOutput("reset_async/sat",  result_sat,  '0);

      // Hold RESET across several edges. The output must stay 0.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0001, 128'd64, "reset_hold");

      applyStimulus(1'b0, 4'b0000, 128'd64, "no_spikes");
      applyStimulus(1'b0, 4'b0001, 128'd18321983, "single_lane");
      applyStimulus(1'b0, 4'b1111,
                    {32'hFFFF_FFF6, 32'd3, 32'd2, 32'd1}, "all_lanes");
      applyStimulus(1'b0, 4'b1000,
                    {32'hFFFF_FFF6, 32'd3, 32'd2, 32'd1}, "lane3_only");
      applyStimulus(1'b0, 4'b0011,
                    {32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, "pos_overflow");
      applyStimulus(1'b0, 4'b0011,
                    {32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000}, "neg_overflow");
      applyStimulus(1'b0, 4'b1111,
                    {32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
                    "neg_overflow4");
      applyStimulus(1'b0, 4'b0100,
                    {32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
                    "single_min");

      // Random stream with two mid-stream resets.
      for (int i = 0; i < 200; i++) begin
         for (int k = 0; k < N; k++) w[k*W +: W] = randWeight();
         sp = N'($urandom);
         if (i == 80) begin
            // Assert RESET between edges and hold it across the next edge.
            // The queued expectation for that edge is 0.
            applyStimulus(1'b0, sp, w, "rand");
            void'(exp_wrap_q.pop_back());
            void'(exp_sat_q.pop_back());
            void'(exp_name_q.pop_back());
            exp_wrap_q.push_back('0);
            exp_sat_q.push_back('0);
            exp_name_q.push_back("reset_mid_hold");
            #2 RESET = 1'b1;
            #1;
            checkOutput("reset_mid_async/wrap", result_wrap, '0);
            checkOutput("reset_mid_async/sat",  result_sat,  '0);
         end else if (i == 150) begin
            // Short pulse that covers no clock edge.
            applyStimulus(1'b0, sp, w, "rand_pre_pulse");
            @(posedge CLK);
            #2 RESET = 1'b1;
            #1;
            checkOutput("reset_pulse/wrap", result_wrap, '0);
            checkOutput("reset_pulse/sat",  result_sat,  '0);
            #1 RESET = 1'b0;
         end else begin
            applyStimulus(1'b0, sp, w, "rand");
         end
      end

      // Let the monitor drain the last entry. Leftover entries are an error.
      @(negedge CLK);
      repeat (2) @(posedge CLK);
      #2;
      checks++;
      if (exp_wrap_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", exp_wrap_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spike_mac.md
# spike_mac

Spike-gated multiply-accumulate for a neuromorphic neuron core. Each cycle it sums the synaptic weights of the input lanes whose spike bit is set and registers the sum as `result`. This is the input-current stage of a neuron: binary spikes select weights, so no multiplier is needed. It sits between the spike router (the `spike_in` source) and the membrane-potential update logic (the `result` consumer).

## Interface

Parameters:
- `N_INPUTS`, default 4: number of spike lanes and weights.
- `WEIGHT_W`, default 32: width of each weight and of `result`.
- `SATURATE`, default 0: 0 = wrap-around on overflow; 1 = clamp to signed min/max.

Ports:
- `CLK`  input  1: single clock, rising-edge.
- `RESET`  input  1: asynchronous, active-high reset.
- `spike_in`  input  N_INPUTS: spike bit per lane.
- `weights_in`  input  N_INPUTS*WEIGHT_W: packed weights. Lane i occupies bits `[i*WEIGHT_W +: WEIGHT_W]`.
- `result`  output  WEIGHT_W: registered sum of the gated weights.

## Operation

- Each weight is signed two's complement.
- Gating:
  - gated_i = weights_in lane i when `spike_in[i]` = 1;
  - gated_i = 0 otherwise.
- Sum:
  - All gated values are sign-extended to WEIGHT_W + clog2(N_INPUTS) bits and added in a balanced adder tree, combinationally within one cycle.
  - Lane order does not affect the result.
- Output conversion:
  - SATURATE = 0: `result` = low WEIGHT_W bits of the full sum (modulo 2^WEIGHT_W).
  - SATURATE = 1: sums above 2^(WEIGHT_W-1)-1 clamp to that value. Sums below -2^(WEIGHT_W-1) clamp to -2^(WEIGHT_W-1).
- `spike_in` = 0 gives `result` = 0, regardless of `weights_in`.
- Exactly one spike set: `result` = that lane's weight. There is no overflow in this case.
- No accumulation across cycles. Each cycle's `result` depends only on the previous cycle's inputs.
- X or Z on an unselected weight lane must not propagate to `result`. The gating is a mux, not a multiply.

## Timing

- Latency: 1 clock. Inputs sampled at rising edge k appear on `result` immediately after edge k.
- Throughput: one new input set per cycle. There is no handshake and no stall.
- Reset:
  - `RESET` high clears `result` to 0 immediately, asynchronously, without waiting for a clock edge.
  - `result` holds 0 on every edge while `RESET` is high.
- First valid output: the first rising edge after `RESET` deasserts samples the inputs. Deassertion is synchronised externally.
- Reset asserted mid-stream: `result` goes to 0 at once, and in-flight data is discarded.
- Inputs must be stable across setup/hold of the `CLK` edge. The combinational path, from `weights_in` through the adder tree and saturation to the register D input, must close in one clock period.

## Test plan

1. Reset: assert `RESET` with `weights_in` = 64 and `spike_in` = 4'b0001 → `result` = 0 asynchronously, and stays 0 across clock edges while `RESET` is high.
2. No spikes: `spike_in` = 4'b0000, `weights_in` = 128'd64, one clock → `result` = 0.
3. Single lane: `spike_in` = 4'b0001, `weights_in` = 128'd18321983, one clock → `result` = 18321983 (0x0117_923F).
4. All lanes: `spike_in` = 4'b1111, lanes 0..3 = 1, 2, 3, -10 → `result` = 0xFFFF_FFFC (-4). Then lane 3 only (`spike_in` = 4'b1000) → `result` = -10.
5. Overflow: `spike_in` = 4'b0011, lanes 0 and 1 = 0x7FFF_FFFF:
   - SATURATE = 0 → `result` = 0xFFFF_FFFE;
   - SATURATE = 1 → `result` = 0x7FFF_FFFF.
   - Negative check: lanes 0 and 1 = 0x8000_0000 with SATURATE = 1 → `result` = 0x8000_0000.
6. Pipeline and mid-stream reset: change inputs every cycle with random spikes and weights, and compare against the modular-sum model with 1-cycle lag. Pulse `RESET` between edges → `result` = 0 immediately. Correct results resume on the first edge after release.
